// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: request/response structs,
// FSM state encoding and the owner identifier.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    typedef struct packed {
        logic              valid;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_type;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way winner selection. With RR_EN a tie goes to the
// requester that did not win last time; otherwise dcache wins ties.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic       ivalid_i,
    input  logic       dvalid_i,
    input  arb_owner_t last_grant_i,
    output arb_owner_t winner_o
);

    // Winner selection; a lone valid requester always wins.
    always_comb begin
        winner_o = OWN_DCACHE;
        if (ivalid_i && dvalid_i) begin
            if (RR_EN && (last_grant_i == OWN_DCACHE)) begin
                winner_o = OWN_ICACHE;
            end else begin
                winner_o = OWN_DCACHE;
            end
        end else if (ivalid_i) begin
            winner_o = OWN_ICACHE;
        end else begin
            winner_o = OWN_DCACHE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the backing memory between icache and dcache.
// One block request is captured and held until the memory is ready, the
// response is routed to the owner, a DONE cycle separates grants, and a
// watchdog aborts a transaction that never completes.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  mem_req_type  imem_req,
    output mem_data_type imem_data,
    input  mem_req_type  dmem_req,
    output mem_data_type dmem_data,
    output mem_req_type  mem_req,
    input  mem_data_type mem_data,
    output logic         busy,
    output logic         timeout_err
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = {WDOG_W{1'b1}};

`ifdef MEM_ARB_RR_EN
    localparam bit RR_SEL = 1'b1;
`else
    localparam bit RR_SEL = 1'b0;
`endif

    arb_state_t         state_q, state_d;
    mem_req_type        req_q, req_d;
    arb_owner_t         owner_q, owner_d;
    arb_owner_t         last_grant_q, last_grant_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               terr_q, terr_d;
    arb_owner_t         win_s;
    mem_data_type       own_rsp_s;
    mem_data_type       imem_rsp_s;
    mem_data_type       dmem_rsp_s;

    mem_arb_pick #(.RR_EN(RR_SEL)) u_pick (
        .ivalid_i     (imem_req.valid),
        .dvalid_i     (dmem_req.valid),
        .last_grant_i (last_grant_q),
        .winner_o     (win_s)
    );

    // State, request, owner, watchdog and error registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            req_q        <= '0;
            owner_q      <= OWN_DCACHE;
            last_grant_q <= OWN_ICACHE;
            wdog_q       <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            terr_q       <= terr_d;
        end
    end

    // Next-state logic and owner response (zero outside BUSY).
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        terr_d       = terr_q;
        own_rsp_s    = '0;
        case (state_q)
            ARB_IDLE: begin
                if (imem_req.valid || dmem_req.valid) begin
                    req_d        = (win_s == OWN_DCACHE) ? dmem_req : imem_req;
                    req_d.valid  = 1'b1;
                    owner_d      = win_s;
                    last_grant_d = win_s;
                    wdog_d       = '0;
                    state_d      = ARB_BUSY;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                own_rsp_s = mem_data;
                if (mem_data.ready) begin
                    req_d.valid = 1'b0;
                    state_d     = ARB_DONE;
                end else if (wdog_q == WDOG_LAST) begin
                    // Lost response: release the owner with an empty block.
                    own_rsp_s.ready = 1'b1;
                    own_rsp_s.data  = '0;
                    terr_d          = 1'b1;
                    req_d.valid     = 1'b0;
                    state_d         = ARB_DONE;
                end else if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end else begin
                    wdog_d = wdog_q;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d     = ARB_IDLE;
                req_d.valid = 1'b0;
            end
        endcase
    end

    // Route the owner response; the non-owner always sees an idle response.
    always_comb begin
        imem_rsp_s = '0;
        dmem_rsp_s = '0;
        if (owner_q == OWN_DCACHE) begin
            dmem_rsp_s = own_rsp_s;
        end else begin
            imem_rsp_s = own_rsp_s;
        end
    end

    assign mem_req     = req_q;
    assign imem_data   = imem_rsp_s;
    assign dmem_data   = dmem_rsp_s;
    assign busy        = (state_q != ARB_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 5-cycle memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam logic [127:0] PAT4 = 128'h00000004_A5A50004_FFFFFFFB_12340004;
    localparam logic [127:0] PAT8 = 128'h00000008_A5A50008_FFFFFFF7_12340008;
    localparam logic [127:0] WDAT = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    logic         clock;
    logic         reset;
    mem_req_type  imem_req;
    mem_data_type imem_data;
    mem_req_type  dmem_req;
    mem_data_type dmem_data;
    mem_req_type  mem_req;
    mem_data_type mem_data;
    logic         busy;
    logic         timeout_err;

    int n_chk;
    int n_pass;

    // memory model
    logic [127:0] mem [0:255];
    logic [2:0]   mcnt;
    logic         mrdy;
    logic [127:0] mdat;
    logic         stall;

    // observation history, indexed by cycle offset from the grant cycle
    int           d_cyc[$];
    int           i_cyc[$];
    logic [127:0] d_dat[$];
    logic [127:0] i_dat[$];
    logic         vld_h  [0:63];
    logic         busy_h [0:63];
    logic         terr_h [0:63];
    logic         drop_d;
    logic         drop_i;
    logic         anyv;

    mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_data   (imem_data),
        .dmem_req    (dmem_req),
        .dmem_data   (dmem_data),
        .mem_req     (mem_req),
        .mem_data    (mem_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [127:0] pat(input int i);
        return {32'(i), 32'hA5A5_0000 | 32'(i), ~32'(i), 32'h1234_0000 + 32'(i)};
    endfunction

    // Memory: ready one cycle after the 5th cycle valid is seen, i.e. grant+7.
    always @(posedge clock) begin
        if (reset) begin
            mcnt <= 3'd0;
            mrdy <= 1'b0;
            mdat <= 128'd0;
            for (int j = 0; j < 256; j++) mem[j] <= pat(j);
        end else if (mrdy) begin
            mrdy <= 1'b0;
            mcnt <= 3'd0;
            mdat <= 128'd0;
        end else if (mem_req.valid && !stall) begin
            if (mcnt == 3'd5) begin
                mrdy <= 1'b1;
                mdat <= mem[mem_req.addr[11:4]];
                if (mem_req.rw) mem[mem_req.addr[11:4]] <= mem_req.data;
                mcnt <= 3'd0;
            end else begin
                mcnt <= mcnt + 3'd1;
            end
        end
    end

    assign mem_data = {mdat, mrdy};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int cyc_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [127:0] dat_at(input logic [127:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 128'hBAD;
    endfunction

    task automatic clr();
        d_cyc.delete();
        i_cyc.delete();
        d_dat.delete();
        i_dat.delete();
        for (int k = 0; k < 64; k++) begin
            vld_h[k]  = 1'b0;
            busy_h[k] = 1'b0;
            terr_h[k] = 1'b0;
        end
    endtask

    task automatic observe(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            @(negedge clock);
            vld_h[k]  = mem_req.valid;
            busy_h[k] = busy;
            terr_h[k] = timeout_err;
            if (dmem_data.ready) begin
                d_cyc.push_back(k);
                d_dat.push_back(dmem_data.data);
                if (drop_d) dmem_req.valid = 1'b0;
            end
            if (imem_data.ready) begin
                i_cyc.push_back(k);
                i_dat.push_back(imem_data.data);
                if (drop_i) imem_req.valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        imem_req = '0;
        dmem_req = '0;
        stall    = 1'b0;
        drop_d   = 1'b1;
        drop_i   = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clr();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        do_reset();

        // reset state
        chk("rst_vld",  128'(mem_req.valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_terr", 128'(timeout_err), 128'd0);
        chk("rst_drdy", 128'(dmem_data.ready), 128'd0);
        chk("rst_irdy", 128'(imem_data.ready), 128'd0);

        // single dcache read of 0x40; addr change while busy is ignored
        dmem_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h40, data: 128'd0};
        observe(1, 1);
        chk("t1_vld1",  128'(mem_req.valid), 128'd1);
        chk("t1_busy1", 128'(busy), 128'd1);
        dmem_req.addr = 32'h0000_0FF0;
        observe(2, 10);
        chk("t1_dcnt", 128'(d_cyc.size()), 128'd1);
        chk("t1_dcyc", 128'(cyc_at(d_cyc, 0)), 128'd7);
        chk("t1_ddat", dat_at(d_dat, 0), PAT4);
        chk("t1_icnt", 128'(i_cyc.size()), 128'd0);
        chk("t1_addr", 128'(mem_req.addr), 128'h40);
        chk("t1_busy8", 128'(busy_h[8]), 128'd1);
        chk("t1_busy9", 128'(busy_h[9]), 128'd0);

        // tie: dcache first, icache granted at T+9, ready at T+16
        do_reset();
        dmem_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h40, data: 128'd0};
        imem_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h80, data: 128'd0};
        observe(1, 18);
        chk("t2_dcyc", 128'(cyc_at(d_cyc, 0)), 128'd7);
        chk("t2_icyc", 128'(cyc_at(i_cyc, 0)), 128'd16);
        chk("t2_idat", dat_at(i_dat, 0), PAT8);
        chk("t2_vld10", 128'(vld_h[10]), 128'd1);

        // repeat tie: last grant was icache, dcache wins again
        dmem_req.valid = 1'b1;
        imem_req.valid = 1'b1;
        clr();
        observe(1, 8);
        chk("t2r_dcyc", 128'(cyc_at(d_cyc, 0)), 128'd7);
        chk("t2r_icnt", 128'(i_cyc.size()), 128'd0);

        // both held for four transactions
        do_reset();
        drop_d = 1'b0;
        drop_i = 1'b0;
        dmem_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h40, data: 128'd0};
        imem_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h80, data: 128'd0};
        observe(1, 36);
`ifdef MEM_ARB_RR_EN
        chk("rr_d0", 128'(cyc_at(d_cyc, 0)), 128'd7);
        chk("rr_i0", 128'(cyc_at(i_cyc, 0)), 128'd16);
        chk("rr_d1", 128'(cyc_at(d_cyc, 1)), 128'd25);
        chk("rr_i1", 128'(cyc_at(i_cyc, 1)), 128'd34);
        chk("rr_idat", dat_at(i_dat, 0), PAT8);
`else
        chk("fp_d0", 128'(cyc_at(d_cyc, 0)), 128'd7);
        chk("fp_d1", 128'(cyc_at(d_cyc, 1)), 128'd16);
        chk("fp_d2", 128'(cyc_at(d_cyc, 2)), 128'd25);
        chk("fp_d3", 128'(cyc_at(d_cyc, 3)), 128'd34);
        chk("fp_icnt", 128'(i_cyc.size()), 128'd0);
`endif
        chk("held_ddat", dat_at(d_dat, 0), PAT4);
        chk("held_vld8",  128'(vld_h[8]), 128'd0);
        chk("held_vld9",  128'(vld_h[9]), 128'd0);
        chk("held_vld10", 128'(vld_h[10]), 128'd1);

        // write 0x100 from dcache, then icache reads it back
        do_reset();
        dmem_req = '{valid: 1'b1, rw: 1'b1, addr: 32'h100, data: WDAT};
        imem_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h100, data: 128'd0};
        observe(1, 18);
        chk("wr_dcyc", 128'(cyc_at(d_cyc, 0)), 128'd7);
        chk("wr_icyc", 128'(cyc_at(i_cyc, 0)), 128'd16);
        chk("wr_idat", dat_at(i_dat, 0), WDAT);
        chk("wr_vld7",  128'(vld_h[7]), 128'd1);
        chk("wr_vld8",  128'(vld_h[8]), 128'd0);
        chk("wr_vld9",  128'(vld_h[9]), 128'd0);
        chk("wr_vld10", 128'(vld_h[10]), 128'd1);

        // stale request: valid kept through DONE, dropped before IDLE
        do_reset();
        drop_d = 1'b0;
        dmem_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h40, data: 128'd0};
        observe(1, 8);
        dmem_req.valid = 1'b0;
        observe(9, 14);
        anyv = 1'b0;
        for (int k = 9; k <= 14; k++) anyv = anyv | vld_h[k];
        chk("stale_novld", 128'(anyv), 128'd0);
        chk("stale_dcnt", 128'(d_cyc.size()), 128'd1);
        chk("stale_busy", 128'(busy_h[14]), 128'd0);

        // watchdog: memory never ready
        do_reset();
        stall = 1'b1;
        dmem_req = '{valid: 1'b1, rw: 1'b0, addr: 32'h40, data: 128'd0};
        observe(1, 20);
        chk("wd_dcnt", 128'(d_cyc.size()), 128'd1);
        chk("wd_dcyc", 128'(cyc_at(d_cyc, 0)), 128'd16);
        chk("wd_ddat", dat_at(d_dat, 0), 128'd0);
        chk("wd_icnt", 128'(i_cyc.size()), 128'd0);
        chk("wd_terr15", 128'(terr_h[15]), 128'd0);
        chk("wd_terr17", 128'(terr_h[17]), 128'd1);
        chk("wd_vld16", 128'(vld_h[16]), 128'd1);
        chk("wd_vld17", 128'(vld_h[17]), 128'd0);
        chk("wd_busy17", 128'(busy_h[17]), 128'd1);
        chk("wd_busy18", 128'(busy_h[18]), 128'd0);
        chk("wd_sticky", 128'(terr_h[20]), 128'd1);

        // reset in the middle of a BUSY transaction
        dmem_req.valid = 1'b1;
        observe(21, 24);
        chk("mr_busy", 128'(busy_h[24]), 128'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("mr_vld",  128'(mem_req.valid), 128'd0);
        chk("mr_addr", 128'(mem_req.addr), 128'd0);
        chk("mr_busy0", 128'(busy), 128'd0);
        chk("mr_terr", 128'(timeout_err), 128'd0);
        chk("mr_drdy", 128'(dmem_data.ready), 128'd0);
        chk("mr_ddat", dmem_data.data, 128'd0);
        chk("mr_irdy", 128'(imem_data.ready), 128'd0);
        reset    = 1'b0;
        dmem_req = '0;
        stall    = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
